// File: rtl/mode_selector.sv
// -----------------------------------------------------------------------------
// mode_selector
//
// Turns one raw, bouncy push-button into the 2-bit animation mode bus.
// Signal path: synchroniser -> debouncer -> edge detect -> press classifier
// (short / long) -> registered mode.
//   - short press (released before LONG_CYCLES): mode advances, wrapping to 0
//   - long press  (held LONG_CYCLES):            mode returns to 0
// Every accepted event produces a one-cycle mode_change strobe in the same
// cycle mode_out takes its new value; releasing a long press is silent.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   btn_in       raw push-button, active-high, asynchronous, may bounce
//   mode_out     current animation mode (registered)
//   mode_change  one-cycle pulse coincident with a mode_out update (registered)
//   btn_level    debounced button level (registered)
// -----------------------------------------------------------------------------
module mode_selector #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16,
    parameter int LONG_CYCLES = 200,
    parameter int NUM_MODES   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic [1:0] mode_out,
    output logic       mode_change,
    output logic       btn_level
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [1:0]        MODE_LAST = 2'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PRESSED   = 2'b01,
        ST_LONG_HELD = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   btn_s;
    logic                   stable_r;
    logic                   stable_d_r;
    logic [DEB_W-1:0]       deb_cnt_r;
    logic [HOLD_W-1:0]      hold_cnt_r;
    logic [HOLD_W-1:0]      hold_inc_s;
    state_t                 state_r;
    logic [1:0]             mode_r;
    logic                   mode_change_r;
    logic                   rise_s;
    logic                   fall_s;

    // Next mode with wrap after the last valid mode.
    function automatic logic [1:0] next_mode(input logic [1:0] cur);
        logic [1:0] nxt;
        if (cur >= MODE_LAST) begin
            nxt = 2'b00;
        end else begin
            nxt = cur + 2'b01;
        end
        return nxt;
    endfunction

    assign btn_s      = sync_r[SYNC_STAGES-1];
    assign rise_s     = stable_r & ~stable_d_r;
    assign fall_s     = ~stable_r & stable_d_r;
    assign hold_inc_s = hold_cnt_r + HOLD_W'(1);

    // Synchroniser chain: btn_in enters at bit 0 and leaves at the top bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
        end
    end

    // Debouncer: a new level is accepted only after DEB_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            deb_cnt_r  <= {DEB_W{1'b0}};
        end else begin
            stable_d_r <= stable_r;
            if (btn_s != stable_r) begin
                if (deb_cnt_r == DEB_LAST) begin
                    stable_r  <= btn_s;
                    deb_cnt_r <= {DEB_W{1'b0}};
                end else begin
                    deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                end
            end else begin
                deb_cnt_r <= {DEB_W{1'b0}};
            end
        end
    end

    // Press classifier and mode register. The long-press decision is taken
    // on the cycle the hold count steps onto LONG_CYCLES-1, so the mode clears
    // LONG_CYCLES-1 cycles after the debounced rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            hold_cnt_r    <= {HOLD_W{1'b0}};
            mode_r        <= 2'b00;
            mode_change_r <= 1'b0;
        end else begin
            mode_change_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        hold_cnt_r <= HOLD_W'(1);
                        state_r    <= ST_PRESSED;
                    end else begin
                        hold_cnt_r <= {HOLD_W{1'b0}};
                        state_r    <= ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (fall_s) begin
                        mode_r        <= next_mode(mode_r);
                        mode_change_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else if (stable_r) begin
                        hold_cnt_r <= hold_inc_s;
                        if (hold_inc_s >= HOLD_FIRE) begin
                            mode_r        <= 2'b00;
                            mode_change_r <= 1'b1;
                            state_r       <= ST_LONG_HELD;
                        end else begin
                            state_r <= ST_PRESSED;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LONG_HELD: begin
                    // Release after a long press is silent.
                    if (fall_s) begin
                        state_r <= ST_IDLE;
                    end else if (hold_cnt_r != HOLD_MAX) begin
                        hold_cnt_r <= hold_inc_s;
                        state_r    <= ST_LONG_HELD;
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                        state_r    <= ST_LONG_HELD;
                    end
                end
                default: begin
                    hold_cnt_r <= {HOLD_W{1'b0}};
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign mode_out    = mode_r;
    assign mode_change = mode_change_r;
    assign btn_level   = stable_r;

endmodule

// File: tb/tb_mode_selector.sv
// -----------------------------------------------------------------------------
// tb_mode_selector
//
// Directed bench for mode_selector with SYNC_STAGES=2, DEB_CYCLES=4,
// LONG_CYCLES=20, NUM_MODES=4. Phases of fixed button level are described in
// a table of {rst, btn, cycles, expected mode, expected level, expected
// strobe count}; latency-sensitive scenarios are hand-written sequences.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mode_selector;

    localparam int SYNC   = 2;
    localparam int DEB    = 4;
    localparam int LONG   = 20;
    localparam int NMODES = 4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       btn_in = 1'b0;
    logic [1:0] mode_out;
    logic       mode_change;
    logic       btn_level;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst;
        logic       btn;
        int         cycles;
        logic [1:0] exp_mode;
        logic       exp_level;
        int         exp_pulses;
    } vec_t;

    vec_t tbl[$];

    mode_selector #(
        .SYNC_STAGES (SYNC),
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG),
        .NUM_MODES   (NMODES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .mode_out    (mode_out),
        .mode_change (mode_change),
        .btn_level   (btn_level)
    );

    always #5 clk = ~clk;

    function automatic void add_row(input logic r, input logic b, input int cyc,
                                    input logic [1:0] m, input logic l, input int p);
        vec_t v;
        v.rst        = r;
        v.btn        = b;
        v.cycles     = cyc;
        v.exp_mode   = m;
        v.exp_level  = l;
        v.exp_pulses = p;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            int pulses;
            pulses = 0;
            rst    = tbl[r].rst;
            btn_in = tbl[r].btn;
            for (int c = 0; c < tbl[r].cycles; c++) begin
                tick();
                if (mode_change) pulses++;
            end
            check($sformatf("row%0d_mode", r), int'(mode_out), int'(tbl[r].exp_mode));
            check($sformatf("row%0d_level", r), int'(btn_level), int'(tbl[r].exp_level));
            check($sformatf("row%0d_pulses", r), pulses, tbl[r].exp_pulses);
        end
    endtask

    // Press for hi cycles then release; measure tick index of level rise,
    // level fall and the first strobe, relative to the cycle btn_in went high.
    task automatic timed_press(input string tag, input int hi, input int total,
                               input logic [1:0] exp_mode);
        int         rise_at = -1;
        int         fall_at = -1;
        int         chg_at  = -1;
        int         pulses  = 0;
        logic [1:0] mode_at_chg = 2'b00;
        btn_in = 1'b1;
        for (int i = 1; i <= total; i++) begin
            tick();
            if (btn_level && rise_at < 0) rise_at = i;
            if (!btn_level && rise_at >= 0 && fall_at < 0) fall_at = i;
            if (mode_change) begin
                pulses++;
                if (chg_at < 0) begin
                    chg_at      = i;
                    mode_at_chg = mode_out;
                end
            end
            if (i == hi) btn_in = 1'b0;
        end
        check({tag, "_rise_at"}, rise_at, SYNC + DEB);
        check({tag, "_fall_at"}, fall_at, hi + SYNC + DEB);
        check({tag, "_chg_at"}, chg_at, hi + SYNC + DEB + 1);
        check({tag, "_mode_at_chg"}, int'(mode_at_chg), int'(exp_mode));
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_mode_end"}, int'(mode_out), int'(exp_mode));
    endtask

    task automatic bounce_seq();
        int level_hi = 0;
        int pulses   = 0;
        for (int i = 0; i < 30; i++) begin
            btn_in = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            if (btn_level) level_hi++;
            if (mode_change) pulses++;
        end
        btn_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (btn_level) level_hi++;
            if (mode_change) pulses++;
        end
        check("bounce_level_hi_cycles", level_hi, 0);
        check("bounce_pulses", pulses, 0);
        check("bounce_mode", int'(mode_out), 0);
    endtask

    task automatic long_seq();
        int         rise_at = -1;
        int         chg_at  = -1;
        int         pulses  = 0;
        int         pulses2 = 0;
        logic [1:0] mode_at_chg = 2'b11;
        btn_in = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (btn_level && rise_at < 0) rise_at = i;
            if (mode_change) begin
                pulses++;
                if (chg_at < 0) begin
                    chg_at      = i;
                    mode_at_chg = mode_out;
                end
            end
        end
        check("long_rise_at", rise_at, SYNC + DEB);
        check("long_chg_delay", chg_at - rise_at, LONG - 1);
        check("long_mode_at_chg", int'(mode_at_chg), 0);
        check("long_pulses_held", pulses, 1);
        check("long_level_held", int'(btn_level), 1);
        btn_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mode_change) pulses2++;
        end
        check("long_pulses_release", pulses2, 0);
        check("long_mode_release", int'(mode_out), 0);
        check("long_level_release", int'(btn_level), 0);
    endtask

    task automatic reset_mid_press_seq();
        btn_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("rstp_level_before", int'(btn_level), 1);
        check("rstp_mode_before", int'(mode_out), 3);
        rst = 1'b1;
        #1;
        check("rstp_mode_async", int'(mode_out), 0);
        check("rstp_level_async", int'(btn_level), 0);
        check("rstp_change_async", int'(mode_change), 0);
        tick();
        rst = 1'b0;
        // btn_in is still high: the released reset looks like a fresh press.
        timed_press("rstp", 10, 30, 2'd1);
    endtask

    initial begin
        // rows 0-1: reset state, then idle
        add_row(1'b1, 1'b0,  3, 2'd0, 1'b0, 0);
        add_row(1'b0, 1'b0, 50, 2'd0, 1'b0, 0);
        // rows 2-10: reset, then four short presses 1,2,3,0
        add_row(1'b1, 1'b0,  2, 2'd0, 1'b0, 0);
        add_row(1'b0, 1'b1, 10, 2'd0, 1'b1, 0);
        add_row(1'b0, 1'b0, 20, 2'd1, 1'b0, 1);
        add_row(1'b0, 1'b1, 10, 2'd1, 1'b1, 0);
        add_row(1'b0, 1'b0, 20, 2'd2, 1'b0, 1);
        add_row(1'b0, 1'b1, 10, 2'd2, 1'b1, 0);
        add_row(1'b0, 1'b0, 20, 2'd3, 1'b0, 1);
        add_row(1'b0, 1'b1, 10, 2'd3, 1'b1, 0);
        add_row(1'b0, 1'b0, 20, 2'd0, 1'b0, 1);
        // rows 11-14: two presses to reach mode 2
        add_row(1'b0, 1'b1, 10, 2'd0, 1'b1, 0);
        add_row(1'b0, 1'b0, 20, 2'd1, 1'b0, 1);
        add_row(1'b0, 1'b1, 10, 2'd1, 1'b1, 0);
        add_row(1'b0, 1'b0, 20, 2'd2, 1'b0, 1);
        // rows 15-20: three presses from 0 to reach mode 3
        add_row(1'b0, 1'b1, 10, 2'd0, 1'b1, 0);
        add_row(1'b0, 1'b0, 20, 2'd1, 1'b0, 1);
        add_row(1'b0, 1'b1, 10, 2'd1, 1'b1, 0);
        add_row(1'b0, 1'b0, 20, 2'd2, 1'b0, 1);
        add_row(1'b0, 1'b1, 10, 2'd2, 1'b1, 0);
        add_row(1'b0, 1'b0, 20, 2'd3, 1'b0, 1);

        run_rows(0, 1);
        timed_press("clean", 10, 30, 2'd1);
        run_rows(2, 10);
        bounce_seq();
        run_rows(11, 14);
        long_seq();
        run_rows(15, 20);
        reset_mid_press_seq();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mode_selector.md
Name: mode_selector

Overview:
- Upstream stage of the LED animation top level. Turns one raw, bouncy push-button into the 2-bit animation mode bus consumed by the animation top's mode input.
- Signal path: synchronise, debounce, classify short/long press, then advance or reset a registered mode.
- Emits a one-cycle change strobe so downstream logic can restart its timers cleanly.

Parameters:
SYNC_STAGES, 2, number of flops in the btn_in synchroniser chain (minimum 2)
DEB_CYCLES, 16, consecutive stable samples required to accept a new button level (minimum 1)
LONG_CYCLES, 200, debounced-high cycles that qualify a press as long (must exceed DEB_CYCLES)
NUM_MODES, 4, number of modes; mode wraps to 0 after NUM_MODES-1 (2..4)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
btn_in  input  1  raw push-button, active-high, asynchronous to clk, may bounce
mode_out  output  2  current animation mode, to the animation top's mode input
mode_change  output  1  one-cycle pulse, high in the same cycle mode_out takes a new value
btn_level  output  1  debounced button level, for status/debug

Behaviour:
- Reset (async, rst=1): sync chain=0, stable level=0, debounce cnt=0, hold cnt=0, state=IDLE, mode_out=0, mode_change=0, btn_level=0. Release of rst takes effect on the next clk edge.
- Synchroniser: btn_in passes through SYNC_STAGES flops; the last flop output is btn_s.
- Debounce:
  - Each cycle with btn_s != stable, deb cnt increments.
  - Each cycle with btn_s == stable, deb cnt clears to 0.
  - When deb cnt == DEB_CYCLES-1 and btn_s != stable, stable <= btn_s and deb cnt <= 0.
  - A bounce shorter than DEB_CYCLES cycles never changes stable. btn_level = stable.
- Edge detect: stable_d is stable delayed by 1 cycle. rise = stable & ~stable_d. fall = ~stable & stable_d.
- Latency:
  - Clean raw edge to btn_level change: SYNC_STAGES + DEB_CYCLES cycles.
  - btn_level fall to mode_out/mode_change update: 1 cycle.
- State machine (IDLE, PRESSED, LONG_HELD):
  - IDLE: on rise, hold cnt <= 1, go to PRESSED. Otherwise stay in IDLE.
  - PRESSED: each cycle stable=1, hold cnt increments.
    - When hold cnt reaches LONG_CYCLES-1 and stable=1: mode_out <= 0, mode_change <= 1, go to LONG_HELD.
    - On fall before that point: mode_out <= (mode_out+1) mod NUM_MODES, mode_change <= 1, go to IDLE.
  - LONG_HELD: hold cnt saturates and does not wrap. On fall, go to IDLE with no mode change and no strobe.
- Arithmetic:
  - Mode increment is done at 2 bits; when mode_out == NUM_MODES-1 the next value is 0.
  - Deb cnt width is clog2(DEB_CYCLES+1). Hold cnt width is clog2(LONG_CYCLES+1). Neither counter may overflow.
- mode_change is high for exactly one cycle per accepted event, and low in every other cycle, including after a long-press release.
- A long press while mode_out is already 0 still pulses mode_change once. Downstream uses the pulse as its restart.
- Simultaneous events: rise and fall cannot occur in the same cycle, because stable changes at most once per DEB_CYCLES.
- Reset mid-press: the state machine returns to IDLE and mode_out returns to 0.
  - If the button is still held when rst deasserts, stable rises DEB_CYCLES+SYNC_STAGES cycles later and starts a new press.
- btn_in held permanently high: exactly one long-press event occurs, then no further events until release.

Test Plan:
- Bench parameters for all scenarios: DEB_CYCLES=4, LONG_CYCLES=20, SYNC_STAGES=2, NUM_MODES=4.
- Reset then idle 50 cycles -> mode_out=0, mode_change never high, btn_level=0.
- Clean press of 10 cycles then release -> btn_level rises 6 cycles after btn_in rises. mode_out 0->1 exactly one cycle after btn_level falls. mode_change high for exactly 1 cycle.
- Four clean short presses, separated by 20 cycles -> mode_out sequence 1,2,3,0. Exactly four mode_change pulses.
- Bounce of btn_in toggling every 2 cycles for 30 cycles, then steady low -> btn_level stays 0, mode_out unchanged, no mode_change.
- Start at mode_out=2, hold btn_in high for 40 cycles -> mode_out=0 with one strobe, 19 cycles after btn_level rises. Release -> no further strobe, mode_out stays 0.
- Assert rst for 1 cycle during a held press at mode_out=3 -> mode_out=0 immediately. btn_level re-rises 6 cycles after rst deasserts. A release then gives mode_out=1.
